// File: rtl/cpu_control_unit.sv
// Hardwired fetch/decode/execute control FSM driving the DataPath control lines.
// Optional single-step gating in F0 is enabled by defining CU_SINGLE_STEP_EN.
module cpu_control_unit #(
    parameter logic [5:0] ADD_OP     = 6'b000011,
    parameter int          WAIT_LIMIT = 16,
    parameter logic [3:0]  LINK_REG   = 4'd15
) (
    input  logic        Clock,
    input  logic        clear,
`ifdef CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] IR,
    input  logic        finished,
    input  logic        memFinished,
    output logic        PCout,
    output logic        IRout,
    output logic        RYout,
    output logic        RZLOout,
    output logic        RZHIout,
    output logic        MARout,
    output logic        RHIout,
    output logic        RLOout,
    output logic        Immout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        RYin,
    output logic        RZin,
    output logic        MARin,
    output logic        RHIin,
    output logic        RLOin,
    output logic        MDRin,
    output logic        RFin,
    output logic        Rin,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [3:0]  RFSelect,
    output logic [5:0]  opSelect,
    output logic        start,
    output logic        Read,
    output logic        Write,
    output logic        halted,
    output logic        error,
    output logic [4:0]  state_dbg
);

    localparam int CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

    typedef enum logic [4:0] {
        S_F0 = 5'd0, S_F1, S_F2, S_DEC,
        S_A1, S_A2, S_A3,
        S_L1, S_L2, S_L3, S_L4, S_L5, S_S4, S_S5,
        S_J1, S_K1, S_K2, S_MH, S_ML,
        S_HALT, S_ERR
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          in_wait, handshake;
    logic [4:0]    opcode;
    logic          is_imm;
    logic          unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign is_imm    = (opcode == 5'b01100) || (opcode == 5'b01101) || (opcode == 5'b01110);
    assign state_dbg = state_reg;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_reg    <= S_F0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        in_wait       = 1'b0;
        handshake     = 1'b0;
        case (state_reg)
`ifdef CU_SINGLE_STEP_EN
            S_F0:  if (step) state_next = S_F1;
`else
            S_F0:  state_next = S_F1;
`endif
            S_F1:  begin in_wait = 1'b1; handshake = memFinished; state_next = S_F2; end
            S_F2:  state_next = S_DEC;
            S_DEC: begin
                case (opcode)
                    5'b00000, 5'b00010:                      state_next = S_L1;
                    5'b00011, 5'b00100, 5'b00101, 5'b00110,
                    5'b01100, 5'b01101, 5'b01110:            state_next = S_A1;
                    5'b10100:                                state_next = S_J1;
                    5'b10101:                                state_next = S_K1;
                    5'b11000:                                state_next = S_MH;
                    5'b11001:                                state_next = S_ML;
                    5'b11010:                                state_next = S_F0;
                    5'b11011:                                state_next = S_HALT;
                    default:                                 state_next = S_ERR;
                endcase
            end
            S_A1:  state_next = S_A2;
            S_A2:  begin in_wait = 1'b1; handshake = finished; state_next = S_A3; end
            S_A3:  state_next = S_F0;
            S_L1:  state_next = S_L2;
            S_L2:  begin in_wait = 1'b1; handshake = finished; state_next = S_L3; end
            S_L3:  state_next = (opcode == 5'b00010) ? S_S4 : S_L4;
            S_L4:  begin in_wait = 1'b1; handshake = memFinished; state_next = S_L5; end
            S_L5:  state_next = S_F0;
            S_S4:  state_next = S_S5;
            S_S5:  begin in_wait = 1'b1; handshake = memFinished; state_next = S_F0; end
            S_J1, S_K2, S_MH, S_ML: state_next = S_F0;
            S_K1:  state_next = S_K2;
            S_HALT: state_next = S_HALT;
            default: state_next = S_ERR;
        endcase
        // A handshake on the limit cycle still wins; only a low handshake can time out.
        if (in_wait && !handshake) begin
            if (wait_cnt_reg == CW'(WAIT_LIMIT - 1)) begin
                state_next = S_ERR;
            end else begin
                state_next    = state_reg;
                wait_cnt_next = wait_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        {PCout, IRout, RYout, RZLOout, RZHIout, MARout, RHIout, RLOout, Immout, MDRout, BAout, Rout} = '0;
        {PCin, IRin, RYin, RZin, MARin, RHIin, RLOin, MDRin, RFin, Rin, IncPC} = '0;
        {Gra, Grb, Grc, start, Read, Write, halted, error} = '0;
        RFSelect = 4'hF;
        opSelect = '0;
        // Outputs are forced quiet while reset is held, even though state is already F0.
        if (clear) begin
            case (state_reg)
`ifdef CU_SINGLE_STEP_EN
                S_F0:  if (step) begin PCout = 1'b1; MARin = 1'b1; end
`else
                S_F0:  begin PCout = 1'b1; MARin = 1'b1; end
`endif
                S_F1:  begin Read = 1'b1; MDRin = 1'b1; end
                S_F2:  begin MDRout = 1'b1; IRin = 1'b1; IncPC = 1'b1; end
                S_A1:  begin Grb = 1'b1; Rout = 1'b1; RYin = 1'b1; end
                S_A2:  begin
                    RZin  = 1'b1;
                    start = (wait_cnt_reg == '0);
                    if (is_imm) begin
                        Immout = 1'b1;
                        case (opcode)
                            5'b01100: opSelect = ADD_OP;
                            5'b01101: opSelect = 6'b000101;
                            default:  opSelect = 6'b000110;
                        endcase
                    end else begin
                        Grc      = 1'b1;
                        Rout     = 1'b1;
                        opSelect = {1'b0, opcode};
                    end
                end
                S_A3:  begin RZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                S_L1:  begin Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
                S_L2:  begin
                    Immout   = 1'b1;
                    RZin     = 1'b1;
                    start    = (wait_cnt_reg == '0);
                    opSelect = ADD_OP;
                end
                S_L3:  begin RZLOout = 1'b1; MARin = 1'b1; end
                S_L4:  begin Read = 1'b1; MDRin = 1'b1; end
                S_L5:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                S_S4:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                S_S5:  Write = 1'b1;
                S_J1, S_K2: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                S_K1:  begin PCout = 1'b1; RFSelect = LINK_REG; RFin = 1'b1; end
                S_MH:  begin RHIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                S_ML:  begin RLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                S_HALT: halted = 1'b1;
                S_ERR:  error = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
